// File: rtl/ysyx_24110015_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// RISC-V func3 width codes and trap cause numbers.
package ysyx_24110015_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [3:0] CAUSE_NONE        = 4'd0;
    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    // Access size in bytes from the low two func3 bits (1/2/4/8).
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/ysyx_24110015_lsu_align.sv
// Byte-lane alignment: store data/mask shifting, access legality check and
// load extraction with sign/zero extension. Purely combinational.
module ysyx_24110015_lsu_align
    import ysyx_24110015_lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NLANE = XLEN / 8,
    localparam int OFF_W = $clog2(NLANE)
) (
    input  logic              i_st_is_load,
    input  logic [2:0]        i_st_func3,
    input  logic [OFF_W-1:0]  i_st_off,
    input  logic [XLEN-1:0]   i_st_wdata,
    output logic [XLEN-1:0]   o_st_wdata,
    output logic [NLANE-1:0]  o_st_wmask,
    output logic              o_bad,
    input  logic [2:0]        i_ld_func3,
    input  logic [OFF_W-1:0]  i_ld_off,
    input  logic [XLEN-1:0]   i_ld_rdata,
    output logic [XLEN-1:0]   o_ld_data
);

    logic [NLANE-1:0] w_ones;
    logic [3:0]       w_size_m1;
    logic             w_misalign;
    logic [XLEN-1:0]  w_shifted;

    // Store lane mask and data shifted up to the byte offset.
    always_comb begin
        w_ones = '0;
        case (i_st_func3[1:0])
            2'd0:    w_ones = NLANE'(8'h01);
            2'd1:    w_ones = NLANE'(8'h03);
            2'd2:    w_ones = NLANE'(8'h0F);
            2'd3:    w_ones = '1;
            default: w_ones = '0;
        endcase
        o_st_wmask = w_ones << i_st_off;
        o_st_wdata = i_st_wdata << {i_st_off, 3'b000};
    end

    // Misaligned offsets and width codes the datapath cannot serve both trap.
    always_comb begin
        w_size_m1  = size_bytes(i_st_func3[1:0]) - 4'd1;
        w_misalign = ((4'(i_st_off) & w_size_m1) != 4'd0);
        if (w_misalign) begin
            o_bad = 1'b1;
        end else if ((XLEN == 32) && (i_st_func3[1:0] == 2'b11)) begin
            o_bad = 1'b1;
        end else if (i_st_is_load && (i_st_func3 == 3'b111)) begin
            o_bad = 1'b1;
        end else if (i_st_is_load && (XLEN == 32) && (i_st_func3 == F3_WU)) begin
            o_bad = 1'b1;
        end else begin
            o_bad = 1'b0;
        end
    end

    // Load: bring the addressed bytes down to lane 0, then extend.
    always_comb begin
        w_shifted = i_ld_rdata >> {i_ld_off, 3'b000};
        case (i_ld_func3)
            F3_B:    o_ld_data = XLEN'($signed(w_shifted[7:0]));
            F3_H:    o_ld_data = XLEN'($signed(w_shifted[15:0]));
            F3_W:    o_ld_data = XLEN'($signed(w_shifted[31:0]));
            F3_D:    o_ld_data = w_shifted;
            F3_BU:   o_ld_data = XLEN'(w_shifted[7:0]);
            F3_HU:   o_ld_data = XLEN'(w_shifted[15:0]);
            F3_WU:   o_ld_data = XLEN'(w_shifted[31:0]);
            default: o_ld_data = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_24110015_lsu.sv
// Load/store unit: one instruction in flight, valid/ready towards EXU,
// memory bus and writeback; traps on misalignment and bus errors.
module ysyx_24110015_lsu
    import ysyx_24110015_lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    localparam int NLANE = XLEN / 8,
    localparam int OFF_W = $clog2(NLANE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [2:0]        in_func3,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [XLEN-1:0]   in_result,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [NLANE-1:0]  mem_req_wmask,
    input  logic              mem_rsp_valid,
    output logic              mem_rsp_ready,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    input  logic              mem_rsp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic              out_exc,
    output logic [3:0]        out_cause
);

    lsu_state_e        r_state;
    logic              r_in_ready;
    logic              r_is_load;
    logic [2:0]        r_func3;
    logic [OFF_W-1:0]  r_off;
    logic              r_mem_req_valid;
    logic              r_mem_req_wen;
    logic [ADDR_W-1:0] r_mem_req_addr;
    logic [XLEN-1:0]   r_mem_req_wdata;
    logic [NLANE-1:0]  r_mem_req_wmask;
    logic              r_mem_rsp_ready;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_out_data;
    logic              r_out_exc;
    logic [3:0]        r_out_cause;

    logic              w_accept;
    logic              w_in_is_load;
    logic              w_in_is_store;
    logic [OFF_W-1:0]  w_in_off;
    logic [ADDR_W-1:0] w_aligned_addr;
    logic [XLEN-1:0]   w_st_wdata;
    logic [NLANE-1:0]  w_st_wmask;
    logic              w_bad;
    logic [XLEN-1:0]   w_ld_data;

    // A request with both read and write set is served as a load.
    assign w_accept       = in_valid & r_in_ready;
    assign w_in_is_load   = in_mem_read;
    assign w_in_is_store  = in_mem_write & ~in_mem_read;
    assign w_in_off       = in_addr[OFF_W-1:0];
    assign w_aligned_addr = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    ysyx_24110015_lsu_align #(.XLEN(XLEN)) u_align (
        .i_st_is_load (w_in_is_load),
        .i_st_func3   (in_func3),
        .i_st_off     (w_in_off),
        .i_st_wdata   (in_wdata),
        .o_st_wdata   (w_st_wdata),
        .o_st_wmask   (w_st_wmask),
        .o_bad        (w_bad),
        .i_ld_func3   (r_func3),
        .i_ld_off     (r_off),
        .i_ld_rdata   (mem_rsp_rdata),
        .o_ld_data    (w_ld_data)
    );

    // Control FSM; every handshake output is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_in_ready      <= 1'b0;
            r_is_load       <= 1'b0;
            r_func3         <= 3'b000;
            r_off           <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_wen   <= 1'b0;
            r_mem_req_addr  <= '0;
            r_mem_req_wdata <= '0;
            r_mem_req_wmask <= '0;
            r_mem_rsp_ready <= 1'b0;
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
            r_out_exc       <= 1'b0;
            r_out_cause     <= CAUSE_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_is_load  <= w_in_is_load;
                        r_func3    <= in_func3;
                        r_off      <= w_in_off;
                        if (!w_in_is_load && !w_in_is_store) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= in_result;
                            r_out_exc   <= 1'b0;
                            r_out_cause <= CAUSE_NONE;
                            r_state     <= ST_RESP;
                        end else if (w_bad) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= '0;
                            r_out_exc   <= 1'b1;
                            r_out_cause <= w_in_is_load ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
                            r_state     <= ST_RESP;
                        end else begin
                            r_mem_req_valid <= 1'b1;
                            r_mem_req_wen   <= w_in_is_store;
                            r_mem_req_addr  <= w_aligned_addr;
                            r_mem_req_wdata <= w_in_is_store ? w_st_wdata : '0;
                            r_mem_req_wmask <= w_in_is_store ? w_st_wmask : '0;
                            r_state         <= ST_REQ;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_mem_rsp_ready <= 1'b1;
                        r_state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_mem_rsp_ready <= 1'b0;
                        r_out_valid     <= 1'b1;
                        r_state         <= ST_RESP;
                        if (mem_rsp_err) begin
                            r_out_data  <= '0;
                            r_out_exc   <= 1'b1;
                            r_out_cause <= r_is_load ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
                        end else begin
                            r_out_data  <= r_is_load ? w_ld_data : '0;
                            r_out_exc   <= 1'b0;
                            r_out_cause <= CAUSE_NONE;
                        end
                    end
                end
                ST_RESP: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state         <= ST_IDLE;
                    r_in_ready      <= 1'b0;
                    r_mem_req_valid <= 1'b0;
                    r_mem_rsp_ready <= 1'b0;
                    r_out_valid     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_wen   = r_mem_req_wen;
    assign mem_req_addr  = r_mem_req_addr;
    assign mem_req_wdata = r_mem_req_wdata;
    assign mem_req_wmask = r_mem_req_wmask;
    assign mem_rsp_ready = r_mem_rsp_ready;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_exc       = r_out_exc;
    assign out_cause     = r_out_cause;

endmodule

// File: tb/tb_ysyx_24110015_lsu.sv
// Directed bench for the LSU: a 32-bit instance for most scenarios and a
// 64-bit instance for doubleword and sign-extended word accesses.
`timescale 1ns/1ps
module tb_ysyx_24110015_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, in_mem_read = 1'b0, in_mem_write = 1'b0;
    logic [2:0]  in_func3 = 3'b000;
    logic [31:0] in_addr = 32'h0, in_wdata = 32'h0, in_result = 32'h0;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid = 1'b0, mem_rsp_ready, mem_rsp_err = 1'b0;
    logic [31:0] mem_rsp_rdata = 32'h0;
    logic        out_valid, out_ready = 1'b0, out_exc;
    logic [31:0] out_data;
    logic [3:0]  out_cause;

    logic        d_in_valid = 1'b0, d_in_ready, d_in_mem_read = 1'b0, d_in_mem_write = 1'b0;
    logic [2:0]  d_in_func3 = 3'b000;
    logic [31:0] d_in_addr = 32'h0;
    logic [63:0] d_in_wdata = 64'h0, d_in_result = 64'h0;
    logic        d_mem_req_valid, d_mem_req_ready = 1'b0, d_mem_req_wen;
    logic [31:0] d_mem_req_addr;
    logic [63:0] d_mem_req_wdata;
    logic [7:0]  d_mem_req_wmask;
    logic        d_mem_rsp_valid = 1'b0, d_mem_rsp_ready, d_mem_rsp_err = 1'b0;
    logic [63:0] d_mem_rsp_rdata = 64'h0;
    logic        d_out_valid, d_out_ready = 1'b0, d_out_exc;
    logic [63:0] d_out_data;
    logic [3:0]  d_out_cause;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_24110015_lsu #(.XLEN(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_func3(in_func3), .in_addr(in_addr), .in_wdata(in_wdata), .in_result(in_result),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_exc(out_exc), .out_cause(out_cause)
    );

    ysyx_24110015_lsu #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_mem_read(d_in_mem_read), .in_mem_write(d_in_mem_write),
        .in_func3(d_in_func3), .in_addr(d_in_addr), .in_wdata(d_in_wdata), .in_result(d_in_result),
        .mem_req_valid(d_mem_req_valid), .mem_req_ready(d_mem_req_ready), .mem_req_wen(d_mem_req_wen),
        .mem_req_addr(d_mem_req_addr), .mem_req_wdata(d_mem_req_wdata), .mem_req_wmask(d_mem_req_wmask),
        .mem_rsp_valid(d_mem_rsp_valid), .mem_rsp_ready(d_mem_rsp_ready),
        .mem_rsp_rdata(d_mem_rsp_rdata), .mem_rsp_err(d_mem_rsp_err),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
        .out_exc(d_out_exc), .out_cause(d_out_cause)
    );

    // Stimulus steps: each starts and ends on a falling edge.
    task automatic step();
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] result);
        in_valid = 1'b1; in_mem_read = rd; in_mem_write = wr; in_func3 = f3;
        in_addr = addr; in_wdata = wdata; in_result = result;
        @(posedge clk); #1;
        in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_accept();
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_respond(input logic [31:0] rdata, input logic err);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata; mem_rsp_err = err;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", mem_req_valid); end
        n_cmp++; if (mem_rsp_ready !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_ready: got %b want 0", mem_rsp_ready); end
        n_cmp++; if (out_valid !== 1'b0 || out_exc !== 1'b0) begin n_bad++; $display("FAIL rst_out: got valid=%b exc=%b want 0/0", out_valid, out_exc); end
        n_cmp++; if (out_data !== 32'h0 || out_cause !== 4'h0) begin n_bad++; $display("FAIL rst_out_data: got %h/%h want 0/0", out_data, out_cause); end
        n_cmp++; if (mem_req_addr !== 32'h0 || mem_req_wmask !== 4'h0) begin n_bad++; $display("FAIL rst_req_fields: got %h/%h want 0/0", mem_req_addr, mem_req_wmask); end
        rst = 1'b0;
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_nonmem();
        issue(1'b0, 1'b0, 3'b000, 32'h8000_0001, 32'h0, 32'h1234_5678);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL nonmem_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 32'h1234_5678) begin n_bad++; $display("FAIL nonmem_data: got %h want 12345678", out_data); end
        n_cmp++; if (out_exc !== 1'b0 || mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL nonmem_noreq: got exc=%b req=%b want 0/0", out_exc, mem_req_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL nonmem_busy: got %b want 0", in_ready); end
        retire();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL nonmem_retire: got valid=%b ready=%b req=%b want 0/1/0", out_valid, in_ready, mem_req_valid); end
    endtask

    task automatic test_store();
        issue(1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'hAABB_CCDD, 32'h0);
        n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_wen !== 1'b1) begin n_bad++; $display("FAIL sb_req: got valid=%b wen=%b want 1/1", mem_req_valid, mem_req_wen); end
        n_cmp++; if (mem_req_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL sb_addr: got %h want 80000000", mem_req_addr); end
        n_cmp++; if (mem_req_wmask !== 4'b1000) begin n_bad++; $display("FAIL sb_wmask: got %b want 1000", mem_req_wmask); end
        n_cmp++; if (mem_req_wdata !== 32'hDD00_0000) begin n_bad++; $display("FAIL sb_wdata: got %h want dd000000", mem_req_wdata); end
        bus_accept();
        n_cmp++; if (mem_rsp_ready !== 1'b1 || mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL sb_wait: got rsp_ready=%b req=%b want 1/0", mem_rsp_ready, mem_req_valid); end
        bus_respond(32'hFFFF_FFFF, 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || out_exc !== 1'b0 || out_data !== 32'h0) begin n_bad++; $display("FAIL sb_done: got v=%b exc=%b data=%h want 1/0/0", out_valid, out_exc, out_data); end
        retire();
        issue(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h1122_3344, 32'h0);
        n_cmp++; if (mem_req_wmask !== 4'b1100 || mem_req_wdata !== 32'h3344_0000) begin n_bad++; $display("FAIL sh_lane: got mask=%b data=%h want 1100/33440000", mem_req_wmask, mem_req_wdata); end
        bus_accept();
        bus_respond(32'h0, 1'b0);
        retire();
        issue(1'b0, 1'b1, 3'b010, 32'h8000_0008, 32'h1122_3344, 32'h0);
        n_cmp++; if (mem_req_wmask !== 4'b1111 || mem_req_wdata !== 32'h1122_3344) begin n_bad++; $display("FAIL sw_lane: got mask=%b data=%h want 1111/11223344", mem_req_wmask, mem_req_wdata); end
        bus_accept();
        bus_respond(32'h0, 1'b1);
        n_cmp++; if (out_exc !== 1'b1 || out_cause !== 4'd7 || out_data !== 32'h0) begin n_bad++; $display("FAIL sw_fault: got exc=%b cause=%0d data=%h want 1/7/0", out_exc, out_cause, out_data); end
        retire();
    endtask

    task automatic test_load();
        issue(1'b1, 1'b0, 3'b000, 32'h8000_0002, 32'h0, 32'h0);
        n_cmp++; if (mem_req_wen !== 1'b0 || mem_req_wmask !== 4'b0000 || mem_req_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL lb_req: got wen=%b mask=%b addr=%h want 0/0000/80000000", mem_req_wen, mem_req_wmask, mem_req_addr); end
        bus_accept();
        bus_respond(32'h0080_0000, 1'b0);
        n_cmp++; if (out_data !== 32'hFFFF_FF80 || out_exc !== 1'b0) begin n_bad++; $display("FAIL lb_data: got %h exc=%b want ffffff80/0", out_data, out_exc); end
        retire();
        issue(1'b1, 1'b0, 3'b100, 32'h8000_0002, 32'h0, 32'h0);
        bus_accept();
        bus_respond(32'h0080_0000, 1'b0);
        n_cmp++; if (out_data !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_data: got %h want 00000080", out_data); end
        retire();
        issue(1'b1, 1'b1, 3'b001, 32'h8000_0002, 32'h0, 32'h0);
        n_cmp++; if (mem_req_wen !== 1'b0) begin n_bad++; $display("FAIL rdwr_is_load: got wen=%b want 0", mem_req_wen); end
        bus_accept();
        bus_respond(32'h8001_0000, 1'b0);
        n_cmp++; if (out_data !== 32'hFFFF_8001) begin n_bad++; $display("FAIL lh_data: got %h want ffff8001", out_data); end
        retire();
        issue(1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h0);
        bus_accept();
        bus_respond(32'h8001_0000, 1'b0);
        n_cmp++; if (out_data !== 32'h0000_8001) begin n_bad++; $display("FAIL lhu_data: got %h want 00008001", out_data); end
        retire();
    endtask

    task automatic test_misalign();
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h0);
        n_cmp++; if (out_valid !== 1'b1 || out_exc !== 1'b1 || out_cause !== 4'd4) begin n_bad++; $display("FAIL lw_mis: got v=%b exc=%b cause=%0d want 1/1/4", out_valid, out_exc, out_cause); end
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL lw_mis_noreq: got %b want 0", mem_req_valid); end
        retire();
        issue(1'b0, 1'b1, 3'b001, 32'h8000_0001, 32'h0, 32'h0);
        n_cmp++; if (out_exc !== 1'b1 || out_cause !== 4'd6 || mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL sh_mis: got exc=%b cause=%0d req=%b want 1/6/0", out_exc, out_cause, mem_req_valid); end
        retire();
        issue(1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0);
        n_cmp++; if (out_exc !== 1'b1 || out_cause !== 4'd4 || mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL ld_on_rv32: got exc=%b cause=%0d req=%b want 1/4/0", out_exc, out_cause, mem_req_valid); end
        retire();
    endtask

    task automatic test_backpressure();
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0004 || mem_req_wmask !== 4'b0000 || in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_req_hold%0d: got v=%b addr=%h mask=%b rdy=%b want 1/80000004/0000/0", i, mem_req_valid, mem_req_addr, mem_req_wmask, in_ready); end
            step();
        end
        bus_accept();
        bus_respond(32'h5555_5555, 1'b1);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_exc !== 1'b1 || out_cause !== 4'd5 || out_data !== 32'h0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_out_hold%0d: got v=%b exc=%b cause=%0d data=%h rdy=%b want 1/1/5/0/0", i, out_valid, out_exc, out_cause, out_data, in_ready); end
            step();
        end
        retire();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_retire: got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0000, 32'h0, 32'h0);
        bus_accept();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_rsp_ready !== 1'b0 || mem_req_valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ctrl: got rsp=%b req=%b v=%b rdy=%b want 0/0/0/0", mem_rsp_ready, mem_req_valid, out_valid, in_ready); end
        n_cmp++; if (out_data !== 32'h0 || out_cause !== 4'h0 || mem_req_addr !== 32'h0) begin n_bad++; $display("FAIL midrst_data: got %h/%0d/%h want 0/0/0", out_data, out_cause, mem_req_addr); end
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_rsp_ready !== 1'b0) begin n_bad++; $display("FAIL stale_rsp: got rdy=%b v=%b rsp=%b want 1/0/0", in_ready, out_valid, mem_rsp_ready); end
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0000, 32'h0, 32'h0);
        bus_accept();
        bus_respond(32'hDEAD_BEEF, 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || out_exc !== 1'b0 || out_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL post_rst_lw: got v=%b exc=%b data=%h want 1/0/deadbeef", out_valid, out_exc, out_data); end
        retire();
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'hCAFE_F00D);
        retire();
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0BAD_F00D);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h0BAD_F00D || in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b: got v=%b data=%h rdy=%b want 1/0badf00d/0", out_valid, out_data, in_ready); end
        retire();
    endtask

    task automatic test_xlen64();
        d_in_valid = 1'b1; d_in_mem_read = 1'b1; d_in_func3 = 3'b011; d_in_addr = 32'h8000_0008;
        step();
        d_in_valid = 1'b0; d_in_mem_read = 1'b0;
        n_cmp++; if (d_mem_req_valid !== 1'b1 || d_mem_req_addr !== 32'h8000_0008) begin n_bad++; $display("FAIL ld64_req: got v=%b addr=%h want 1/80000008", d_mem_req_valid, d_mem_req_addr); end
        d_mem_req_ready = 1'b1; step(); d_mem_req_ready = 1'b0;
        d_mem_rsp_valid = 1'b1; d_mem_rsp_rdata = 64'h0123_4567_89AB_CDEF; step(); d_mem_rsp_valid = 1'b0;
        n_cmp++; if (d_out_valid !== 1'b1 || d_out_exc !== 1'b0 || d_out_data !== 64'h0123_4567_89AB_CDEF) begin n_bad++; $display("FAIL ld64_data: got v=%b exc=%b data=%h want 1/0/0123456789abcdef", d_out_valid, d_out_exc, d_out_data); end
        d_out_ready = 1'b1; step(); d_out_ready = 1'b0;
        d_in_valid = 1'b1; d_in_mem_read = 1'b1; d_in_func3 = 3'b010; d_in_addr = 32'h8000_000C;
        step();
        d_in_valid = 1'b0; d_in_mem_read = 1'b0;
        d_mem_req_ready = 1'b1; step(); d_mem_req_ready = 1'b0;
        d_mem_rsp_valid = 1'b1; d_mem_rsp_rdata = 64'h8000_0000_0000_0000; step(); d_mem_rsp_valid = 1'b0;
        n_cmp++; if (d_out_data !== 64'hFFFF_FFFF_8000_0000) begin n_bad++; $display("FAIL lw64_sext: got %h want ffffffff80000000", d_out_data); end
        d_out_ready = 1'b1; step(); d_out_ready = 1'b0;
        d_in_valid = 1'b1; d_in_mem_write = 1'b1; d_in_func3 = 3'b011; d_in_addr = 32'h8000_0010;
        d_in_wdata = 64'h0123_4567_89AB_CDEF;
        step();
        d_in_valid = 1'b0; d_in_mem_write = 1'b0;
        n_cmp++; if (d_mem_req_wmask !== 8'hFF || d_mem_req_wdata !== 64'h0123_4567_89AB_CDEF || d_mem_req_wen !== 1'b1) begin n_bad++; $display("FAIL sd64: got mask=%h data=%h wen=%b want ff/0123456789abcdef/1", d_mem_req_wmask, d_mem_req_wdata, d_mem_req_wen); end
        d_mem_req_ready = 1'b1; step(); d_mem_req_ready = 1'b0;
        d_mem_rsp_valid = 1'b1; d_mem_rsp_rdata = 64'h0; step(); d_mem_rsp_valid = 1'b0;
        d_out_ready = 1'b1; step(); d_out_ready = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_nonmem();
        test_store();
        test_load();
        test_misalign();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_xlen64();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_24110015_lsu.md
Name: ysyx_24110015_lsu

Overview:
Parametrised load/store unit that takes over memory access from the single-cycle execute stage. Replaces direct combinational memory calls with a valid/ready request/response bus, so memory latency is arbitrary. Adds byte-lane alignment, sign/zero extension, misalignment detection and bus-error reporting. Sits between the EXU (address/data/func3) and writeback; non-memory results pass through it so the pipeline sees one uniform handshake.

Parameters:
XLEN, 32, datapath width; 32 or 64.
ADDR_W, 32, memory address width.
NLANE, XLEN/8, byte lanes (derived, not overridable).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  EXU has an instruction
in_ready  out  1  LSU can accept
in_mem_read  in  1  load
in_mem_write  in  1  store
in_func3  in  3  RISC-V width/sign code
in_addr  in  ADDR_W  effective address (ALU result)
in_wdata  in  XLEN  store data (rs2)
in_result  in  XLEN  non-memory result, passed through
mem_req_valid  out  1  bus request
mem_req_ready  in  1  bus accepts request
mem_req_wen  out  1  1=write
mem_req_addr  out  ADDR_W  in_addr aligned down to NLANE
mem_req_wdata  out  XLEN  lane-shifted store data
mem_req_wmask  out  NLANE  lane-shifted byte mask
mem_rsp_valid  in  1  response present
mem_rsp_ready  out  1  LSU takes response
mem_rsp_rdata  in  XLEN  read data, full aligned word
mem_rsp_err  in  1  bus error
out_valid  out  1  result available
out_ready  in  1  writeback accepts
out_data  out  XLEN  load data or in_result
out_exc  out  1  exception flag
out_cause  out  4  4 load-misaligned, 5 load-fault, 6 store-misaligned, 7 store-fault; 0 if none

Behaviour:
- Reset (sync, active-high): state IDLE; in_ready, mem_req_valid, mem_rsp_ready, out_valid, out_exc = 0; out_data, out_cause, mem_req_* = 0. in_ready rises the first cycle after rst falls.
- States IDLE, REQ, WAIT, RESP. in_ready = (state==IDLE). Only one instruction in flight.
- IDLE, accept (in_valid & in_ready): latch all in_* fields.
  - Neither read nor write -> RESP, out_data = in_result, out_exc = 0.
  - Both read and write set: treated as a load.
  - Misaligned (offset = addr mod size not 0; size 1/2/4/8 from func3[1:0]) -> RESP, out_exc=1, cause 4 or 6, no bus request.
  - func3[1:0]==3 with XLEN=32, or illegal load code (011 at XLEN=32, 110 at XLEN=32, 111): treated as misaligned (cause 4/6).
  - Otherwise -> REQ.
- REQ: mem_req_valid=1. All mem_req_* held stable until mem_req_ready. wmask = size-wide ones << lane offset; wdata = in_wdata << 8*offset; wen=0 -> wmask=0. Handshake -> WAIT.
- WAIT: mem_rsp_ready=1. On mem_rsp_valid: if err, out_exc=1, cause 5/7, out_data=0. Else for loads, shift rdata right by 8*offset, then extend: 000 sb, 001 sh, 010 sw (sign-extended at XLEN=64), 011 d, 100 bu, 101 hu, 110 wu. Stores: out_data=0. -> RESP. A response in the same cycle as the request handshake is not legal; the bus responds no earlier than the following cycle.
- RESP: out_valid=1, outputs stable until out_ready. On handshake -> IDLE. out_valid drops the following cycle.
- Latency, zero stall: non-mem accept at T -> out_valid T+1. Memory accept T -> req T+1 -> rsp earliest T+2 -> out_valid T+3.
- Throughput: one instruction per (latency + 1) cycles. No accept in the cycle RESP retires.
- Reset mid-operation: returns to IDLE at once; mem_req_valid low the next cycle. The bus is reset together with the LSU. Any stale mem_rsp_valid seen in IDLE is ignored, and mem_rsp_ready is 0 there.
- Reg widths: offset = addr[log2(NLANE)-1:0]. Shifts are done at XLEN width, and overflow lanes are discarded.

Decomposition:
- Shared package/header: state encoding (IDLE/REQ/WAIT/RESP), func3 load/store codes, exception cause constants.
- One sub-module, ysyx_24110015_lsu_align: combinational store shift/mask generation and load extract/extend, parametrised by XLEN. The FSM stays in the top module.

Test Plan:
- Non-mem: in_result=0x1234_5678, out_ready=1 -> out_valid at T+1, out_data=0x12345678, no mem_req_valid ever.
- sb addr=0x8000_0003, wdata=0xAABBCCDD -> mem_req_addr=0x8000_0000, wmask=4'b1000, wdata=0xDD00_0000. rsp ok -> out_exc=0.
- lb addr=0x8000_0002, rdata=0x0080_0000 -> out_data=0xFFFF_FF80. lbu at the same address -> 0x0000_0080.
- lw addr=0x8000_0002 -> no request, out_exc=1, cause=4 at T+1. sh addr=...1 -> cause=6.
- Backpressure: mem_req_ready low 3 cycles, then rsp_err=1 on lw; out_ready low 2 cycles -> req fields stable throughout, cause=5, out held stable, in_ready=0 until retire.
- rst asserted while in WAIT -> next cycle IDLE, all outputs 0. A following lw completes normally. XLEN=64 run: ld addr=...8 -> mask irrelevant, out_data = full rdata.
